// File: rtl/feeder_pkg.sv
// feeder_pkg: shared timer state encoding and dispenser-controller state codes.
// Also provides the reload floor helper used by the interval timer.
package feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELOAD,
        S_COUNT,
        S_HOLD,
        S_SENSE
    } timer_state_t;

    localparam logic [1:0] FS_WAIT  = 2'b01;
    localparam logic [1:0] FS_SENSE = 2'b00;
    localparam logic [1:0] FS_DISP  = 2'b10;
    localparam logic [1:0] FS_BAD   = 2'b11;

    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every CLK_DIV cycles.
// clr restarts the phase so the first tick lands CLK_DIV cycles after release.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == LAST) && !clr;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_cnt <= '0;
        else
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/feed_interval_timer.sv
// feed_interval_timer: counts the automatic feed interval in ticks, then
// holds and times the sensor window, flagging a sticky timeout.
module feed_interval_timer
    import feeder_pkg::*;
#(
    parameter int          CLK_DIV      = 50_000_000,
    parameter logic [15:0] DEF_INTERVAL = 16'd3600,
    parameter logic [15:0] DEF_WINDOW   = 16'd60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        modo,
    input  logic [1:0]  fsm_state,
    input  logic        load,
    input  logic [15:0] interval_in,
    input  logic [15:0] window_in,
    output logic [15:0] cont,
    output logic        expired,
    output logic        timeout
);
    timer_state_t r_state;
    logic [15:0]  r_cont, r_interval, r_window, r_win_cnt;
    logic         r_expired, r_timeout;
    logic         w_tick, w_clr;
    logic [15:0]  w_interval, w_window;

    assign w_clr      = (r_state == S_IDLE) || (r_state == S_RELOAD);
    assign w_interval = load ? interval_in : r_interval;
    assign w_window   = load ? window_in : r_window;
    assign cont       = r_cont;
    assign expired    = r_expired;
    assign timeout    = r_timeout;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cont     <= DEF_INTERVAL;
            r_interval <= DEF_INTERVAL;
            r_window   <= DEF_WINDOW;
            r_win_cnt  <= DEF_WINDOW;
            r_expired  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (load) begin
                r_interval <= interval_in;
                r_window   <= window_in;
            end
            if (!modo) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_RELOAD;
                    S_RELOAD: begin
                        r_cont    <= at_least_one(w_interval);
                        r_win_cnt <= at_least_one(w_window);
                        r_state   <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (w_tick && fsm_state == FS_WAIT && r_cont != 16'd0) begin
                            r_cont <= r_cont - 16'd1;
                            if (r_cont == 16'd1) begin
                                r_state   <= S_HOLD;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        r_cont  <= 16'd0;
                        r_state <= (fsm_state == FS_SENSE) ? S_SENSE :
                                   (fsm_state == FS_DISP)  ? S_RELOAD : S_HOLD;
                    end
                    S_SENSE: begin
                        r_cont <= 16'd0;
                        if (fsm_state == FS_DISP) begin
                            r_state <= S_RELOAD;
                        end else if (w_tick && fsm_state != FS_BAD && r_win_cnt != 16'd0) begin
                            r_win_cnt <= r_win_cnt - 16'd1;
                            if (r_win_cnt == 16'd1)
                                r_timeout <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // A load in the same cycle as a timeout set wins and clears it.
            if (load)
                r_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_feed_interval_timer.sv
// tb_feed_interval_timer: directed sequence with an expectation queue,
// CLK_DIV=4 so one tick is four clk cycles.
module tb_feed_interval_timer;
    localparam logic [15:0] DI = 16'd10;
    localparam logic [15:0] DW = 16'd5;

    logic        clk = 1'b0;
    logic        reset, modo, load;
    logic [1:0]  fsm_state;
    logic [15:0] interval_in, window_in;
    logic [15:0] cont;
    logic        expired, timeout;

    typedef struct {
        string       tag;
        logic [15:0] c;
        logic        e;
        logic        t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    feed_interval_timer #(.CLK_DIV(4), .DEF_INTERVAL(DI), .DEF_WINDOW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .modo       (modo),
        .fsm_state  (fsm_state),
        .load       (load),
        .interval_in(interval_in),
        .window_in  (window_in),
        .cont       (cont),
        .expired    (expired),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic [15:0] c, input logic e, input logic t);
        exp_t x;
        sb.push_back('{tag, c, e, t});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        assert ({cont, expired, timeout} === {x.c, x.e, x.t}) else begin
            errors++;
            $error("FAIL %s: got cont=%0d expired=%b timeout=%b, want cont=%0d expired=%b timeout=%b",
                   x.tag, cont, expired, timeout, x.c, x.e, x.t);
        end
    endtask

    initial begin
        reset = 1'b1; modo = 1'b0; load = 1'b0; fsm_state = 2'b01;
        interval_in = 16'd0; window_in = 16'd0;
        cyc("reset0", DI, 1'b0, 1'b0);
        cyc("reset1", DI, 1'b0, 1'b0);
        reset = 1'b0; modo = 1'b1; load = 1'b1; interval_in = 16'd3; window_in = 16'd2;
        cyc("idle_to_reload", DI, 1'b0, 1'b0);
        load = 1'b0;
        cyc("reload_3", 16'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 13; i++)
            cyc("count_3", 16'(3 - i / 4), i == 12, 1'b0);
        fsm_state = 2'b00;
        for (int i = 0; i < 6; i++)
            cyc("sense_window", 16'd0, 1'b0, 1'b0);
        cyc("timeout_set", 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc("timeout_sticky", 16'd0, 1'b0, 1'b1);
        load = 1'b1; interval_in = 16'd5; window_in = 16'd3;
        cyc("load_clears_timeout", 16'd0, 1'b0, 1'b0);
        load = 1'b0;
        cyc("no_retrigger0", 16'd0, 1'b0, 1'b0);
        cyc("no_retrigger1", 16'd0, 1'b0, 1'b0);
        fsm_state = 2'b10;
        cyc("disp_to_reload", 16'd0, 1'b0, 1'b0);
        fsm_state = 2'b01;
        cyc("reload_5", 16'd5, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++)
            cyc("count_5", 16'(5 - i / 4), 1'b0, 1'b0);
        modo = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc("idle_holds_2", 16'd2, 1'b0, 1'b0);
        modo = 1'b1;
        cyc("idle_to_reload2", 16'd2, 1'b0, 1'b0);
        cyc("reload_after_idle", 16'd5, 1'b0, 1'b0);
        modo = 1'b0;
        cyc("idle_again", 16'd5, 1'b0, 1'b0);
        modo = 1'b1;
        cyc("idle_to_reload3", 16'd5, 1'b0, 1'b0);
        load = 1'b1; interval_in = 16'd0; window_in = 16'd1;
        cyc("reload_bypass_min1", 16'd1, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("count_1", 16'd1, 1'b0, 1'b0);
        cyc("expire_min1", 16'd0, 1'b1, 1'b0);
        fsm_state = 2'b00;
        for (int i = 0; i < 3; i++)
            cyc("sense_win1", 16'd0, 1'b0, 1'b0);
        cyc("timeout_win1", 16'd0, 1'b0, 1'b1);
        fsm_state = 2'b11;
        cyc("invalid_ignored0", 16'd0, 1'b0, 1'b1);
        cyc("invalid_ignored1", 16'd0, 1'b0, 1'b1);
        reset = 1'b1; load = 1'b1; interval_in = 16'd7;
        cyc("reset_in_sense", DI, 1'b0, 1'b0);
        reset = 1'b0; load = 1'b0; fsm_state = 2'b01;
        cyc("post_reset_idle", DI, 1'b0, 1'b0);
        cyc("post_reset_reload_def", DI, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
